// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Purpose  : Registered ALU with a valid/ready handshake on both sides.
//            Single-cycle operations return their result one cycle after
//            acceptance. Unsigned multiply runs as a shift-and-add sequence,
//            one partial-product bit per cycle. The output register holds
//            its result until the consumer takes it.
// Options  : ALU_SAT_EN - when defined, add/sub saturate on signed overflow
//            instead of wrapping.
// Ports    : clk, rst_n              clock, async active-low reset
//            in_valid/in_ready       operation handshake
//            a, b, cin, opcode       operands, carry in, operation select
//            shift_amt               shift/rotate distance
//            out_valid/out_ready     result handshake
//            res                     result
//            cout, zero, sign,
//            overflow                result flags
//            busy                    multiply in progress
// Revision : 1.0 - initial release
// ============================================================================
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [3:0]       opcode,
    input  logic [SHW-1:0]   shift_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             cout,
    output logic             zero,
    output logic             sign,
    output logic             overflow,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_INC = 4'b0110;
    localparam logic [3:0] OP_DEC = 4'b0111;
    localparam logic [3:0] OP_SHL = 4'b1000;
    localparam logic [3:0] OP_SHR = 4'b1001;
    localparam logic [3:0] OP_ROL = 4'b1010;
    localparam logic [3:0] OP_ROR = 4'b1011;
    localparam logic [3:0] OP_MUL = 4'b1100;

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    LAST_IT = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic                 cout_q, cout_d;
    logic                 zero_q, zero_d;
    logic                 sign_q, sign_d;
    logic                 ovf_q, ovf_d;
    logic                 out_valid_q, out_valid_d;

    logic                 accept;
    logic [2*WIDTH-1:0]   mul_step;

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic [WIDTH:0]       add_full, sub_full, inc_full;
    logic [WIDTH:0]       shl_ext, shr_ext;
    logic [SHW-1:0]       rot_amt;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_cout, alu_ovf;

    assign add_full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign sub_full = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
    assign inc_full = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
    // One guard bit catches the last bit shifted out; it stays 0 for a zero shift.
    assign shl_ext  = {1'b0, a} << shift_amt;
    assign shr_ext  = {a, 1'b0} >> shift_amt;
    assign rot_amt  = SHW'({{(32-SHW){1'b0}}, shift_amt} % WIDTH);

    always_comb begin
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_res  = add_full[WIDTH-1:0];
                alu_cout = add_full[WIDTH];
                alu_ovf  = (a[WIDTH-1] == b[WIDTH-1]) &&
                           (add_full[WIDTH-1] != a[WIDTH-1]);
`ifdef ALU_SAT_EN
                // Overflow direction follows the sign of a.
                if (alu_ovf) alu_res = a[WIDTH-1] ? MIN_NEG : MAX_POS;
`endif
            end
            OP_SUB: begin
                alu_res  = sub_full[WIDTH-1:0];
                alu_cout = sub_full[WIDTH];
                alu_ovf  = (a[WIDTH-1] != b[WIDTH-1]) &&
                           (sub_full[WIDTH-1] != a[WIDTH-1]);
`ifdef ALU_SAT_EN
                if (alu_ovf) alu_res = a[WIDTH-1] ? MIN_NEG : MAX_POS;
`endif
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_NOT: alu_res = ~a;
            OP_INC: begin
                alu_res  = inc_full[WIDTH-1:0];
                alu_cout = inc_full[WIDTH];
                alu_ovf  = (a == MAX_POS);
            end
            OP_DEC: begin
                alu_res  = a - {{(WIDTH-1){1'b0}}, 1'b1};
                alu_cout = (a == '0);
                alu_ovf  = (a == MIN_NEG);
            end
            OP_SHL: begin
                alu_res  = shl_ext[WIDTH-1:0];
                alu_cout = shl_ext[WIDTH];
            end
            OP_SHR: begin
                alu_res  = shr_ext[WIDTH:1];
                alu_cout = shr_ext[0];
            end
            OP_ROL: alu_res = (a << rot_amt) | (a >> (WIDTH - int'(rot_amt)));
            OP_ROR: alu_res = (a >> rot_amt) | (a << (WIDTH - int'(rot_amt)));
            default: begin
                alu_res  = '0;
                alu_cout = 1'b0;
                alu_ovf  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control and output register
    // ------------------------------------------------------------------
    assign busy     = (state_q == S_MUL);
    assign in_ready = !busy && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign mul_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        cout_d      = cout_q;
        zero_d      = zero_q;
        sign_d      = sign_q;
        ovf_d       = ovf_q;
        // A held result drops only when the consumer takes it.
        out_valid_d = out_valid_q && !out_ready;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (opcode == OP_MUL) begin
                        // in_ready implies the output slot is free by now,
                        // so the product never collides with a held result.
                        state_d  = S_MUL;
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end else begin
                        res_d       = alu_res;
                        cout_d      = alu_cout;
                        ovf_d       = alu_ovf;
                        zero_d      = (alu_res == '0);
                        sign_d      = alu_res[WIDTH-1];
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d    = mul_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_IT) begin
                    state_d     = S_IDLE;
                    res_d       = mul_step[WIDTH-1:0];
                    cout_d      = |mul_step[2*WIDTH-1:WIDTH];
                    ovf_d       = |mul_step[2*WIDTH-1:WIDTH];
                    zero_d      = (mul_step[WIDTH-1:0] == '0);
                    sign_d      = mul_step[WIDTH-1];
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            res_q       <= '0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
            sign_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            cout_q      <= cout_d;
            zero_q      <= zero_d;
            sign_q      <= sign_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign cout      = cout_q;
    assign zero      = zero_q;
    assign sign      = sign_q;
    assign overflow  = ovf_q;

endmodule
`default_nettype wire
